// File: rtl/uart_pkg.sv
// uart_pkg: shared counter constants and the saturating, clearable event-counter step.
package uart_pkg;
    localparam int COUNT_WIDTH = 16;
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = 16'hFFFF;
    typedef logic [COUNT_WIDTH-1:0] count_t;
    // A clear wins over the old value, but an event in the same cycle still counts once.
    function automatic count_t sat_count(input count_t cnt, input logic ev, input logic clr);
        return clr ? count_t'(ev) : (ev && cnt != COUNT_MAX) ? cnt + count_t'(1) : cnt;
    endfunction
endpackage

// File: rtl/uart_fifo_ram.sv
// uart_fifo_ram: simple dual-port storage, registered write-first read port, no reset.
module uart_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        rdata_q <= (we && waddr == raddr) ? wdata : mem_q[raddr];
    end
    assign rdata = rdata_q;
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: FWFT receive FIFO with registered output stage, occupancy flags and error counters.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  frame_error_in,
    input  logic                  overrun_error_in,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  full,
    output logic                  empty,
    output logic [15:0]           drop_count,
    output logic [15:0]           frame_count,
    output logic [15:0]           overrun_count,
    input  logic                  clear_counts
);
    localparam logic [ADDR_WIDTH:0] DEPTH_LVL = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic                  full_q, full_d, empty_q, empty_d;
    logic                  tvalid_q, tvalid_d, tready_q, tready_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d, ram_rdata;
    count_t                drop_q, drop_d, frame_q, frame_d, overrun_q, overrun_d;
    logic                  wr, drop, pop, load;
    // The RAM reads at the next read pointer, so its output always holds the oldest unloaded byte.
    always_comb begin
        wr        = s_axis_tvalid && tready_q && !full_q;
        drop      = s_axis_tvalid && tready_q && full_q;
        pop       = tvalid_q && m_axis_tready;
        load      = (level_q != (ADDR_WIDTH+1)'(tvalid_q)) && (!tvalid_q || pop);
        wr_ptr_d  = wr_ptr_q + ADDR_WIDTH'(wr);
        rd_ptr_d  = rd_ptr_q + ADDR_WIDTH'(load);
        level_d   = level_q + (ADDR_WIDTH+1)'(wr) - (ADDR_WIDTH+1)'(pop);
        full_d    = level_d == DEPTH_LVL;
        empty_d   = level_d == '0;
        tvalid_d  = load || (tvalid_q && !pop);
        tdata_d   = load ? ram_rdata : tdata_q;
        tready_d  = 1'b1;
        drop_d    = sat_count(drop_q, drop, clear_counts);
        frame_d   = sat_count(frame_q, frame_error_in, clear_counts);
        overrun_d = sat_count(overrun_q, overrun_error_in, clear_counts);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            tvalid_q  <= 1'b0;
            tdata_q   <= '0;
            tready_q  <= 1'b0;
            drop_q    <= '0;
            frame_q   <= '0;
            overrun_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            tvalid_q  <= tvalid_d;
            tdata_q   <= tdata_d;
            tready_q  <= tready_d;
            drop_q    <= drop_d;
            frame_q   <= frame_d;
            overrun_q <= overrun_d;
        end
    end
    uart_fifo_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk  (clk),
        .we   (wr),
        .waddr(wr_ptr_q),
        .wdata(s_axis_tdata),
        .raddr(rd_ptr_d),
        .rdata(ram_rdata)
    );
    assign s_axis_tready = tready_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign level         = level_q;
    assign full          = full_q;
    assign empty         = empty_q;
    assign drop_count    = drop_q;
    assign frame_count   = frame_q;
    assign overrun_count = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed checks of latency, full/drop, wrap, counters and reset of uart_rx_fifo.
module tb_uart_rx_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_tdata = '0;
    logic        s_tvalid = 1'b0, s_tready;
    logic        frame_err = 1'b0, overrun_err = 1'b0, clear = 1'b0;
    logic [7:0]  m_tdata;
    logic        m_tvalid, m_tready = 1'b0;
    logic [4:0]  level;
    logic        full, empty;
    logic [15:0] drop_cnt, frame_cnt, overrun_cnt;
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    uart_rx_fifo dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .frame_error_in(frame_err), .overrun_error_in(overrun_err),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .level(level), .full(full), .empty(empty),
        .drop_count(drop_cnt), .frame_count(frame_cnt), .overrun_count(overrun_cnt),
        .clear_counts(clear)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic [15:0] exp_drop);
        chk({tag, "_level"}, 32'(level), 0);
        chk({tag, "_empty"}, 32'(empty), 1);
        chk({tag, "_full"}, 32'(full), 0);
        chk({tag, "_tvalid"}, 32'(m_tvalid), 0);
        chk({tag, "_drop"}, 32'(drop_cnt), 32'(exp_drop));
    endtask

    initial begin
        tick();
        tick();
        chk("rst_tready", 32'(s_tready), 0);
        chk("rst_tdata", 32'(m_tdata), 0);
        chk("rst_frame", 32'(frame_cnt), 0);
        chk("rst_overrun", 32'(overrun_cnt), 0);
        chk_idle("rst", 16'd0);
        rst = 1'b0;
        tick();
        chk("tready_after_rst", 32'(s_tready), 1);
        // single byte latency
        m_tready = 1'b1;
        s_tdata = 8'hA5;
        s_tvalid = 1'b1;
        tick();
        s_tvalid = 1'b0;
        chk("lat_n_tvalid", 32'(m_tvalid), 0);
        chk("lat_n_level", 32'(level), 1);
        tick();
        chk("lat_n1_tvalid", 32'(m_tvalid), 1);
        chk("lat_n1_tdata", 32'(m_tdata), 32'h A5);
        tick();
        chk_idle("lat_done", 16'd0);
        // fill to full, drop the 17th, drain in order
        m_tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s_tdata = 8'(i);
            s_tvalid = 1'b1;
            tick();
        end
        chk("fill_level", 32'(level), 16);
        chk("fill_full", 32'(full), 1);
        chk("fill_empty", 32'(empty), 0);
        s_tdata = 8'hFF;
        tick();
        s_tvalid = 1'b0;
        chk("fill_drop", 32'(drop_cnt), 1);
        chk("fill_level_after_drop", 32'(level), 16);
        chk("fill_hold_tdata", 32'(m_tdata), 0);
        m_tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_tvalid", 32'(m_tvalid), 1);
            chk("drain_tdata", 32'(m_tdata), 32'(i));
            tick();
        end
        chk_idle("drain_done", 16'd1);
        // pop and write together at full: the write is still dropped
        m_tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s_tdata = 8'(8'h10 + i);
            s_tvalid = 1'b1;
            tick();
        end
        chk("full2_full", 32'(full), 1);
        m_tready = 1'b1;
        s_tdata = 8'h55;
        tick();
        s_tvalid = 1'b0;
        chk("popwr_drop", 32'(drop_cnt), 2);
        chk("popwr_level", 32'(level), 15);
        chk("popwr_full", 32'(full), 0);
        for (int i = 1; i < 16; i++) begin
            chk("popwr_drain", 32'(m_tdata), 32'(8'h10 + i));
            chk("popwr_drain_valid", 32'(m_tvalid), 1);
            tick();
        end
        chk_idle("popwr_done", 16'd2);
        // 40 bytes streamed through with pointer wraps
        for (int j = 0; j < 42; j++) begin
            s_tvalid = j < 40;
            s_tdata = 8'(8'h40 + j);
            tick();
            chk("stream_tvalid", 32'(m_tvalid), 32'(j >= 1 && j <= 40));
            if (j >= 1 && j <= 40) chk("stream_tdata", 32'(m_tdata), 32'(8'h40 + j - 1));
        end
        chk_idle("stream_done", 16'd2);
        // counter saturation and clear
        frame_err = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        chk("frame_fffe", 32'(frame_cnt), 32'hFFFE);
        tick();
        chk("frame_ffff", 32'(frame_cnt), 32'hFFFF);
        repeat (4465) @(posedge clk);
        #1;
        frame_err = 1'b0;
        chk("frame_sat", 32'(frame_cnt), 32'hFFFF);
        overrun_err = 1'b1;
        tick();
        tick();
        tick();
        chk("overrun_3", 32'(overrun_cnt), 3);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        overrun_err = 1'b0;
        chk("clr_overrun", 32'(overrun_cnt), 1);
        chk("clr_frame", 32'(frame_cnt), 0);
        chk("clr_drop", 32'(drop_cnt), 0);
        // reset mid-stream
        m_tready = 1'b0;
        frame_err = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_tdata = 8'(8'hC0 + i);
            s_tvalid = 1'b1;
            tick();
            frame_err = 1'b0;
        end
        s_tvalid = 1'b0;
        chk("pre_rst_level", 32'(level), 5);
        chk("pre_rst_tvalid", 32'(m_tvalid), 1);
        chk("pre_rst_frame", 32'(frame_cnt), 1);
        rst = 1'b1;
        s_tvalid = 1'b1;
        m_tready = 1'b1;
        frame_err = 1'b1;
        tick();
        chk("mid_rst_tready", 32'(s_tready), 0);
        chk("mid_rst_tdata", 32'(m_tdata), 0);
        chk("mid_rst_frame", 32'(frame_cnt), 0);
        chk("mid_rst_overrun", 32'(overrun_cnt), 0);
        chk_idle("mid_rst", 16'd0);
        rst = 1'b0;
        s_tvalid = 1'b0;
        frame_err = 1'b0;
        tick();
        s_tdata = 8'h77;
        s_tvalid = 1'b1;
        tick();
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        tick();
        chk("post_rst_tdata", 32'(m_tdata), 32'h77);
        chk("post_rst_level", 32'(level), 1);
        chk("post_rst_drop", 32'(drop_cnt), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
